// File: rtl/aes_spi_pkg.sv
// Shared frame geometry and FSM state encoding for the AES SPI slave endpoint.
package aes_spi_pkg;

  localparam int unsigned FRAME_BITS  = 256;
  localparam int unsigned KEY_BITS    = 128;
  localparam int unsigned RESULT_BITS = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DELIVER = 2'd2
  } state_e;

endpackage

// File: rtl/aes_spi_slave_if.sv
// Key/plaintext hand-off and ciphertext return path between the SPI slave and the AES core.
interface aes_spi_slave_if
  import aes_spi_pkg::*;
#(
  parameter int unsigned DATA_W = RESULT_BITS,
  parameter int unsigned KEY_W  = KEY_BITS
);

  logic [KEY_W-1:0]  key_out;
  logic [DATA_W-1:0] data_out;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;

  modport slave (
    output key_out,
    output data_out,
    output in_valid,
    input  in_ready,
    input  res_data,
    input  res_valid
  );

  modport master (
    input  key_out,
    input  data_out,
    input  in_valid,
    output in_ready,
    output res_data,
    output res_valid
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Synchroniser chain for one asynchronous SPI pin, with single-cycle rise/fall pulses.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // Fewer than two stages is not a safe synchroniser; clamp rather than fail.
  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], din};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign dout = sync_q[Stages-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/aes_spi_slave.sv
// SPI mode-0 slave: collects a key+plaintext frame for the AES core and returns the last
// ciphertext on MISO during the first half of the following frame.
module aes_spi_slave
  import aes_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = RESULT_BITS,
  parameter int unsigned KEY_W       = KEY_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  output logic            miso,
  aes_spi_slave_if.slave  aes,
  output logic            busy,
  output logic            frame_err
);

  localparam int unsigned RxW    = KEY_W + DATA_W;
  localparam int unsigned CntW   = $clog2(RxW + 1);
  localparam int unsigned TxIdxW = $clog2(DATA_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs_n), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [RxW-1:0]    rx_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] pend_q;
  logic              res_pending_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] data_q;
  logic              in_valid_q;
  logic              frame_err_q;
  logic              miso_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      pend_q        <= '0;
      res_pending_q <= 1'b0;
      key_q         <= '0;
      data_q        <= '0;
      in_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // Results arriving outside RECV go straight to tx; RECV stages them in pend_q.
      if (aes.res_valid && state_q != RECV) tx_q <= aes.res_data;

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= RECV;
            cnt_q   <= '0;
            rx_q    <= '0;
            miso_q  <= aes.res_valid ? aes.res_data[DATA_W-1] : tx_q[DATA_W-1];
          end
        end
        RECV: begin
          if (sclk_rise && cnt_q != CntW'(RxW)) begin
            rx_q  <= {rx_q[RxW-2:0], mosi_s};
            cnt_q <= cnt_q + CntW'(1);
          end
          // cnt_q rises already sampled == index of the next bit the master will read.
          if (sclk_fall) begin
            miso_q <= (cnt_q < CntW'(DATA_W)) ? tx_q[~cnt_q[TxIdxW-1:0]] : 1'b0;
          end
          if (cs_rise) begin
            if (cnt_q == CntW'(RxW)) begin
              key_q      <= rx_q[RxW-1:DATA_W];
              data_q     <= rx_q[DATA_W-1:0];
              in_valid_q <= 1'b1;
              state_q    <= DELIVER;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end
            if (aes.res_valid) tx_q <= aes.res_data;
            else if (res_pending_q) tx_q <= pend_q;
            res_pending_q <= 1'b0;
          end else if (aes.res_valid) begin
            pend_q        <= aes.res_data;
            res_pending_q <= 1'b1;
          end
        end
        DELIVER: begin
          if (aes.in_ready) begin
            in_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
          if (cs_rise) frame_err_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign aes.key_out  = key_q;
  assign aes.data_out = data_q;
  assign aes.in_valid = in_valid_q;
  assign miso         = miso_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed bench for aes_spi_slave: drives SPI frames at sclk = clk/8 and checks hand-off,
// readback, short frames, pending results and dropped frames.
module tb_aes_spi_slave;

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ResR = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ResA = 128'haaaa5555aaaa5555aaaa5555aaaa5555;
  localparam logic [127:0] ResB = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] Key2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] Pt2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] Key3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Pt3  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Key4 = 128'hdeadbeefcafef00d0badc0de12345678;
  localparam logic [127:0] Pt4  = 128'h8badf00d5eed1e55feedfacec0ffee00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;
  logic busy;
  logic frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  aes_spi_slave_if u_if ();

  aes_spi_slave u_dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .aes      (u_if),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic pulse_res(input logic [127:0] val);
    u_if.res_data  = val;
    u_if.res_valid = 1'b1;
    @(negedge clk);
    u_if.res_valid = 1'b0;
  endtask

  // Master side of one frame; captures the MISO bit seen at each sclk rise into cap[255-i].
  task automatic spi_frame(input logic [255:0] bits, input int nbits,
                           input int rv1_bit, input logic [127:0] rv1_val,
                           input int rv2_bit, input logic [127:0] rv2_val,
                           output logic [255:0] cap);
    cap = '0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rv1_bit) pulse_res(rv1_val);
      if (i == rv2_bit) pulse_res(rv2_val);
      mosi = bits[255-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      cap[255-i] = miso;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_handshake();
    @(negedge clk);
    u_if.in_ready = 1'b1;
    @(negedge clk);
    u_if.in_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
    checks++; if (u_if.key_out !== '0) begin errors++; $display("FAIL reset_key got %h want 0", u_if.key_out); end
    checks++; if (u_if.data_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", u_if.data_out); end
    checks++; if (u_if.in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %b want 0", u_if.in_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL post_reset_miso got %b want 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    logic [255:0] cap;
    int fe0;
    fe0 = fe_cnt;
    spi_frame({Key1, Pt1}, 256, -1, '0, -1, '0, cap);
    checks++; if (cap !== '0) begin errors++; $display("FAIL nominal_miso got %h want 0", cap); end
    checks++; if (u_if.key_out !== Key1) begin errors++; $display("FAIL nominal_key got %h want %h", u_if.key_out, Key1); end
    checks++; if (u_if.data_out !== Pt1) begin errors++; $display("FAIL nominal_data got %h want %h", u_if.data_out, Pt1); end
    checks++; if (u_if.in_valid !== 1'b1) begin errors++; $display("FAIL nominal_in_valid got %b want 1", u_if.in_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy got %b want 1", busy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (u_if.in_valid !== 1'b1 || u_if.key_out !== Key1 || u_if.data_out !== Pt1) begin
        errors++;
        $display("FAIL nominal_hold cycle %0d got v=%b key=%h data=%h want v=1 key=%h data=%h",
                 c, u_if.in_valid, u_if.key_out, u_if.data_out, Key1, Pt1);
      end
    end
    u_if.in_ready = 1'b1;
    @(negedge clk);
    u_if.in_ready = 1'b0;
    checks++; if (u_if.in_valid !== 1'b0) begin errors++; $display("FAIL nominal_accept_valid got %b want 0", u_if.in_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_accept_busy got %b want 0", busy); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL nominal_frame_err got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_readback();
    logic [255:0] cap;
    @(negedge clk);
    pulse_res(ResR);
    spi_frame({Key2, Pt2}, 256, -1, '0, -1, '0, cap);
    checks++; if (cap[255:128] !== ResR) begin errors++; $display("FAIL readback_hi got %h want %h", cap[255:128], ResR); end
    checks++; if (cap[127:0] !== '0) begin errors++; $display("FAIL readback_lo got %h want 0", cap[127:0]); end
    checks++; if (u_if.key_out !== Key2) begin errors++; $display("FAIL readback_key got %h want %h", u_if.key_out, Key2); end
    do_handshake();
  endtask

  task automatic test_short_frame();
    logic [255:0] cap;
    int fe0;
    fe0 = fe_cnt;
    spi_frame({Key3, Pt3}, 200, -1, '0, -1, '0, cap);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL short_frame_err got %0d cycles want 1", fe_cnt - fe0); end
    checks++; if (u_if.in_valid !== 1'b0) begin errors++; $display("FAIL short_in_valid got %b want 0", u_if.in_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b want 0", busy); end
    checks++; if (u_if.key_out !== Key2) begin errors++; $display("FAIL short_key got %h want %h", u_if.key_out, Key2); end
    checks++; if (u_if.data_out !== Pt2) begin errors++; $display("FAIL short_data got %h want %h", u_if.data_out, Pt2); end
    // tx is not consumed by shifting, so the same result comes back again.
    checks++; if (cap[255:128] !== ResR) begin errors++; $display("FAIL short_repeat got %h want %h", cap[255:128], ResR); end
  endtask

  task automatic test_pending();
    logic [255:0] cap;
    spi_frame({Key3, Pt3}, 256, 50, ResA, 90, ResB, cap);
    checks++; if (cap[255:128] !== ResR) begin errors++; $display("FAIL pending_midframe got %h want %h", cap[255:128], ResR); end
    checks++; if (u_if.data_out !== Pt3) begin errors++; $display("FAIL pending_data got %h want %h", u_if.data_out, Pt3); end
    do_handshake();
    spi_frame({Key4, Pt4}, 256, -1, '0, -1, '0, cap);
    checks++; if (cap[255:128] !== ResB) begin errors++; $display("FAIL pending_last_wins got %h want %h", cap[255:128], ResB); end
    checks++; if (u_if.key_out !== Key4) begin errors++; $display("FAIL pending_key got %h want %h", u_if.key_out, Key4); end
    do_handshake();
  endtask

  task automatic test_busy_drop();
    logic [255:0] cap;
    int fe0;
    spi_frame({Key1, Pt1}, 256, -1, '0, -1, '0, cap);
    fe0 = fe_cnt;
    spi_frame({Key2, Pt2}, 256, -1, '0, -1, '0, cap);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL drop_frame_err got %0d cycles want 1", fe_cnt - fe0); end
    checks++; if (u_if.key_out !== Key1) begin errors++; $display("FAIL drop_key got %h want %h", u_if.key_out, Key1); end
    checks++; if (u_if.data_out !== Pt1) begin errors++; $display("FAIL drop_data got %h want %h", u_if.data_out, Pt1); end
    checks++; if (u_if.in_valid !== 1'b1) begin errors++; $display("FAIL drop_in_valid got %b want 1", u_if.in_valid); end
    do_handshake();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_final_busy got %b want 0", busy); end
  endtask

  initial begin
    u_if.in_ready  = 1'b0;
    u_if.res_valid = 1'b0;
    u_if.res_data  = '0;
    test_reset();
    test_nominal();
    test_readback();
    test_short_frame();
    test_pending();
    test_busy_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
